// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_NIBBLE = 4;

  // Smallest digit count d such that 10^d > 2^width - 1.
  function automatic int min_digits(input int width);
    longint unsigned max_v;
    longint unsigned p;
    int              d;
    max_v = (64'd1 << width) - 64'd1;
    p     = 64'd1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (p <= max_v) begin
        p = p * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_adj3.sv
// One double-dabble digit correction: add 3 to a BCD nibble holding 5 or more.
module bin2bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] i_d,
  output logic [BCD_NIBBLE-1:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SEQ_SIGNED_EN for two's-complement input with a neg output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd,
  output logic                         busy
`ifdef BIN2BCD_SEQ_SIGNED_EN
  ,
  output logic                         neg
`endif
);

  localparam int BW    = BCD_NIBBLE * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_chk
    $error("bin2bcd_seq: WIDTH=%0d outside supported range 4..32", WIDTH);
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d, need at least %0d",
           DIGITS, WIDTH, min_digits(WIDTH));
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_acc;
  logic [BW-1:0]    r_bcd;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_load;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;

`ifdef BIN2BCD_SEQ_SIGNED_EN
  logic r_sign;
  logic r_neg;
  // Unary minus in WIDTH bits maps -2^(WIDTH-1) onto its own unsigned magnitude.
  assign w_load = bin[WIDTH-1] ? -bin : bin;
  assign neg    = r_neg;
`else
  assign w_load = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_adj3 u_adj3 (
      .i_d (r_acc[g*BCD_NIBBLE +: BCD_NIBBLE]),
      .o_d (w_adj[g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  assign {w_acc_nxt, w_sr_nxt} = {w_adj, r_sr} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bcd       <= '0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
      r_neg       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Final step: publish the shifted accumulator on the same edge.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_bcd       <= w_acc_nxt;
`ifdef BIN2BCD_SEQ_SIGNED_EN
            r_neg       <= r_sign;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Working registers are always reloaded on accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sr  <= w_load;
      r_acc <= '0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
      r_sign <= bin[WIDTH-1];
`endif
    end else if (r_state == SHIFT) begin
      r_sr  <= w_sr_nxt;
      r_acc <= w_acc_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bcd       = r_bcd;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
- REQ-001 Parameter: WIDTH, default 8, binary input width; legal range 4..32.
- REQ-002 Parameter: DIGITS, default 3, number of BCD output digits.
- REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004 Port: rst  input  1  asynchronous, active-high reset.
- REQ-005 Port: in_valid  input  1  a conversion request is present on bin.
- REQ-006 Port: in_ready  output  1  block can accept a request.
- REQ-007 Port: bin  input  WIDTH  binary operand; unsigned unless REQ-024 applies.
- REQ-008 Port: out_valid  output  1  bcd holds a completed result.
- REQ-009 Port: out_ready  input  1  consumer takes the result.
- REQ-010 Port: bcd  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0], most significant digit at the top.
- REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
- REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE. Transitions: IDLE->SHIFT on in_valid&&in_ready; SHIFT->DONE after WIDTH iterations; DONE->IDLE on out_valid&&out_ready.
- REQ-013 in_ready SHALL equal (state==IDLE); the block SHALL NOT accept a request in SHIFT or DONE.
- REQ-014 On the accepting edge, bin SHALL be captured into an internal shift register and the BCD accumulator cleared; later changes on bin SHALL have no effect.
- REQ-015 Each SHIFT cycle SHALL run one double-dabble step: add 3 to every accumulator digit >=5, then shift {accumulator, operand} left by one bit.
- REQ-016 out_valid SHALL rise exactly WIDTH rising edges after the accepting edge, e.g. 8 cycles for WIDTH=8.
- REQ-017 In DONE, out_valid SHALL stay high and bcd SHALL stay stable until out_ready is sampled high; back-pressure of any length SHALL be tolerated.
- REQ-018 in_ready SHALL be high on the cycle after the out handshake. Back-to-back throughput is one result per WIDTH+2 cycles.
- REQ-019 bcd SHALL hold the last result through IDLE and SHIFT, and SHALL be zero after reset.
- REQ-020 The digits of bcd SHALL satisfy sum(digit_i*10^i) == bin, with every digit in 0..9, for all 2^WIDTH inputs.
- REQ-021 Elaboration SHALL fail with a clear message if 10^DIGITS <= 2^WIDTH-1 (DIGITS too small).

Reset
- REQ-022 rst SHALL force state=IDLE, in_ready=1, out_valid=0, busy=0, bcd=0, and clear the iteration counter. This SHALL happen immediately and asynchronously, including mid-SHIFT or in DONE.
- REQ-023 After rst deasserts, the first request SHALL convert correctly, with no residue from an aborted conversion.

Configuration
- REQ-024 With macro BIN2BCD_SEQ_SIGNED_EN defined:
  - bin SHALL be two's complement.
  - An extra output port neg (1 bit) SHALL report the sign.
  - The converted magnitude SHALL be |bin|; -2^(WIDTH-1) yields magnitude 2^(WIDTH-1).
  - neg SHALL follow the same valid, hold and reset rules as bcd.
- REQ-025 Without BIN2BCD_SEQ_SIGNED_EN, the neg port SHALL NOT exist and bin SHALL be unsigned.

Structure
- REQ-026 Package bin2bcd_pkg SHALL hold:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the BCD_NIBBLE width constant (4);
  - the constant function min_digits(width) used by the REQ-021 check.
- REQ-027 Sub-module bin2bcd_adj3 (4-bit in, 4-bit out: add 3 if >=5) SHALL be instantiated DIGITS times via generate; all other logic stays in bin2bcd_seq.

Verification
- REQ-028 WIDTH=8, DIGITS=3: bin=255 with in_valid pulse, out_ready=1 -> out_valid high exactly 8 edges after accept, bcd=12'h255; then bin=0 -> 12'h000.
- REQ-029 WIDTH=8: exhaustive 0..255 with out_ready=1 -> every bcd matches REQ-020 with digits <=9; spot values 9->009, 10->010, 99->099, 100->100.
- REQ-030 Back-pressure: convert 137, hold out_ready=0 for 20 cycles -> out_valid and bcd=12'h137 stable, in_ready=0, and a new in_valid is ignored. Release -> in_ready=1 on the next cycle.
- REQ-031 Reset mid-operation: assert rst on the 4th SHIFT cycle of converting 200 -> in_ready=1, out_valid=0 and bcd=0 immediately. After release, convert 42 -> 12'h042.
- REQ-032 WIDTH=16, DIGITS=5: 65535 -> 20'h65535, 16 cycles latency. Also instantiate WIDTH=16, DIGITS=4 -> elaboration error.
- REQ-033 With BIN2BCD_SEQ_SIGNED_EN, WIDTH=8: -128 -> neg=1, 12'h128; -1 -> neg=1, 12'h001; 127 -> neg=0, 12'h127.
